mm_job_sequencer: RTL

- Controller that sequences one 2x2 matrix-multiply job on the team's 8-bit 2x2 multiplier datapath.
- Accepts the 8 operand bytes over a valid/ready stream and drives the multiplier's execute / sel_in / input_val / sel_out pins.
- Returns the 4 17-bit products over a second valid/ready stream.
- Sits between the host-side byte interface and the multiplier; owns all multiplier control pins.

---
 rtl/mm_pkg.sv | 33 +++
 rtl/mm_job_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 matrix-multiply job sequencer: widths, FSM states,
// operand and result slot indices.
package mm_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 17;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        DRAIN
    } state_e;

    localparam logic [2:0] IDX_A00 = 3'd0;
    localparam logic [2:0] IDX_A01 = 3'd1;
    localparam logic [2:0] IDX_A10 = 3'd2;
    localparam logic [2:0] IDX_A11 = 3'd3;
    localparam logic [2:0] IDX_B00 = 3'd4;
    localparam logic [2:0] IDX_B01 = 3'd5;
    localparam logic [2:0] IDX_B10 = 3'd6;
    localparam logic [2:0] IDX_B11 = 3'd7;

    localparam logic [1:0] IDX_C00 = 2'd0;
    localparam logic [1:0] IDX_C01 = 2'd1;
    localparam logic [1:0] IDX_C10 = 2'd2;
    localparam logic [1:0] IDX_C11 = 2'd3;

    function automatic logic is_last_operand(input logic [2:0] idx);
        return idx == IDX_B11;
    endfunction

endpackage

// File: rtl/mm_job_sequencer.sv
// Sequences one 2x2 matrix-multiply job: streams 8 operand bytes into the multiplier,
// waits one settle cycle, then streams the 4 products out with valid/ready.
module mm_job_sequencer #(
    parameter int DATA_W     = mm_pkg::DATA_W,
    parameter int RES_W      = mm_pkg::RES_W,
    parameter int CNT_W      = 16,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    output logic [1:0]        out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  job_count,
    output logic              mm_execute,
    output logic [2:0]        mm_sel_in,
    output logic [DATA_W-1:0] mm_input_val,
    output logic [1:0]        mm_sel_out,
    input  logic [RES_W-1:0]  mm_out
);
    import mm_pkg::*;

    state_e           state_q, state_d;
    logic [2:0]       load_cnt_q, load_cnt_d;
    logic [1:0]       out_idx_q, out_idx_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] job_count_q, job_count_d;
    logic             load_hs;

    // The multiplier captures its operand on every edge with execute low, so execute
    // may only drop on a real, non-aborted handshake.
    assign load_hs = (state_q == LOAD) && in_valid && !abort;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;
        job_count_d = job_count_q;

        if (state_q != IDLE && abort) begin
            state_d    = IDLE;
            load_cnt_d = 3'd0;
            out_idx_d  = IDX_C00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (AUTO_START ? in_valid : start) state_d = LOAD;
                end
                LOAD: begin
                    if (in_valid) begin
                        load_cnt_d = load_cnt_q + 3'd1;
                        if (is_last_operand(load_cnt_q)) state_d = SETTLE;
                    end
                end
                SETTLE: state_d = DRAIN;
                DRAIN: begin
                    if (out_ready) begin
                        out_idx_d = out_idx_q + 2'd1;
                        if (out_idx_q == IDX_C11) begin
                            state_d     = IDLE;
                            done_d      = 1'b1;
                            job_count_d = job_count_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            load_cnt_q  <= 3'd0;
            out_idx_q   <= IDX_C00;
            done_q      <= 1'b0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
            job_count_q <= job_count_d;
        end
    end

    assign in_ready     = (state_q == LOAD);
    assign out_valid    = (state_q == DRAIN);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign job_count    = job_count_q;
    assign out_idx      = out_idx_q;
    assign out_data     = mm_out;
    assign mm_execute   = !load_hs;
    assign mm_sel_in    = load_cnt_q;
    assign mm_input_val = in_data;
    assign mm_sel_out   = out_idx_q;

endmodule
